// File: rtl/drops_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drops_pkg : shared types and helpers for the BuildingDrops random picker  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package drops_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } picker_state_t;

  localparam int REJECT_CNT_W = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rand_range_picker_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rand_bit_collector : packs serial random bits MSB-first into a W-bit word |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rand_bit_collector
  import drops_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_en,
  input  logic         rand_bit,
  input  logic         clear,
  output logic [W-1:0] word,
  output logic         word_done
);

  localparam int CNT_W = clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [W-1:0]     shifted;

  generate
    if (W == 1) begin : g_single_bit
      assign shifted = rand_bit;
    end else begin : g_multi_bit
      assign shifted = {acc_q[W-2:0], rand_bit};
    end
  endgenerate

  always_comb begin
    acc_d     = acc_q;
    bitcnt_d  = bitcnt_q;
    word_done = 1'b0;
    if (clear) begin
      bitcnt_d = '0;
    end else if (bit_en) begin
      acc_d = shifted;
      if (bitcnt_q == LAST_BIT) begin
        bitcnt_d  = '0;
        word_done = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      bitcnt_q <= '0;
    end else begin
      acc_q    <= acc_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign word = acc_q;

endmodule
`default_nettype wire

// File: rtl/rand_range_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rand_range_picker : uniform [OFFSET, OFFSET+RANGE-1] via rejection        |
// | sampling with bounded-latency fallback.  Rev 1.0                          |
// +--------------------------------------------------------------------------+
module rand_range_picker
  import drops_pkg::*;
#(
  parameter int RANGE     = 10,
  parameter int OFFSET    = 0,
  parameter int MAX_TRIES = 4,
  parameter int OUT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rand_bit,
  input  logic                    bit_en,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_value,
  output logic                    out_fallback,
  output logic [REJECT_CNT_W-1:0] reject_cnt
);

  localparam int W = clog2(RANGE);
  localparam logic [W:0]       RANGE_V   = (W + 1)'(RANGE);
  localparam logic [OUT_W-1:0] OFFSET_V  = OUT_W'(OFFSET);
  localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

  generate
    if ((OFFSET + RANGE - 1) >= (1 << OUT_W)) begin : g_out_w_check
      $error("rand_range_picker: OFFSET+RANGE-1 does not fit in OUT_W bits");
    end
  endgenerate

  picker_state_t           state_q, state_d;
  logic [3:0]              tries_q, tries_d, tries_inc;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_value_q, out_value_d;
  logic                    out_fallback_q, out_fallback_d;
  logic [REJECT_CNT_W-1:0] reject_cnt_q, reject_cnt_d;

  logic [W-1:0] word;
  logic         word_done;
  logic         collect_en;
  logic [W:0]   sample;

  // Bits are only consumed while filling; CHECK and HOLD leave the stream untouched.
  assign collect_en = bit_en && (state_q == FILL);
  assign sample     = {1'b0, word};
  assign tries_inc  = tries_q + 4'd1;

  rand_bit_collector #(.W(W)) u_collector (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (collect_en),
    .rand_bit  (rand_bit),
    .clear     (state_q != FILL),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_d        = state_q;
    tries_d        = tries_q;
    out_valid_d    = out_valid_q;
    out_value_d    = out_value_q;
    out_fallback_d = out_fallback_q;
    reject_cnt_d   = reject_cnt_q;
    case (state_q)
      FILL: begin
        if (word_done) state_d = CHECK;
      end
      CHECK: begin
        if (sample < RANGE_V) begin
          out_value_d    = OUT_W'(sample) + OFFSET_V;
          out_fallback_d = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = HOLD;
        end else begin
          if (reject_cnt_q != '1) reject_cnt_d = reject_cnt_q + REJECT_CNT_W'(1);
          tries_d = tries_inc;
          if (tries_inc == TRIES_MAX) begin
            // sample < 2*RANGE, so folding it down by RANGE always lands in range.
            out_value_d    = OUT_W'(sample - RANGE_V) + OFFSET_V;
            out_fallback_d = 1'b1;
            out_valid_d    = 1'b1;
            state_d        = HOLD;
          end else begin
            state_d = FILL;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = FILL;
          tries_d     = '0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      tries_q        <= '0;
      out_valid_q    <= 1'b0;
      out_value_q    <= '0;
      out_fallback_q <= 1'b0;
      reject_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      tries_q        <= tries_d;
      out_valid_q    <= out_valid_d;
      out_value_q    <= out_value_d;
      out_fallback_q <= out_fallback_d;
      reject_cnt_q   <= reject_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_fallback = out_fallback_q;
  assign reject_cnt   = reject_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_range_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rand_range_picker : directed checks of the range picker               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_rand_range_picker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rand_bit, bit_en, out_ready;
  logic       out_valid, out_fallback;
  logic [7:0] out_value, reject_cnt;

  logic       rst8, rand_bit8, bit_en8, out_ready8;
  logic       out_valid8, out_fallback8;
  logic [7:0] out_value8, reject_cnt8;

  int n_checks = 0;
  int n_pass   = 0;

  rand_range_picker #(.RANGE(10), .OFFSET(3), .MAX_TRIES(4), .OUT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rand_bit     (rand_bit),
    .bit_en       (bit_en),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_value    (out_value),
    .out_fallback (out_fallback),
    .reject_cnt   (reject_cnt)
  );

  rand_range_picker #(.RANGE(8), .OFFSET(0), .MAX_TRIES(4), .OUT_W(8)) dut8 (
    .clk          (clk),
    .rst          (rst8),
    .rand_bit     (rand_bit8),
    .bit_en       (bit_en8),
    .out_ready    (out_ready8),
    .out_valid    (out_valid8),
    .out_value    (out_value8),
    .out_fallback (out_fallback8),
    .reject_cnt   (reject_cnt8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic b, input logic en);
    rand_bit = b;
    bit_en   = en;
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) step(bits[i], 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    int         hold_err;
    int         seq_err;
    int         range_err;
    int         fb_seen;
    logic [15:0] lfsr;
    logic [2:0] model_acc;
    logic [7:0] seen;
    logic       b;

    rst = 1'b1; rand_bit = 1'b0; bit_en = 1'b0; out_ready = 1'b0;
    rst8 = 1'b1; rand_bit8 = 1'b0; bit_en8 = 1'b1; out_ready8 = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("reset_valid", out_valid, 0);
    check("reset_value", out_value, 0);
    check("reset_fallback", out_fallback, 0);
    check("reset_rejects", reject_cnt, 0);

    // Accept path: 0111 = 7 -> 7+3 = 10, valid at cycle 5
    rst = 1'b0;
    feed4(4'b0111);
    check("accept_cycle4_valid", out_valid, 0);
    step(1'b1, 1'b1);
    check("accept_cycle5_valid", out_valid, 1);
    check("accept_value", out_value, 10);
    check("accept_fallback", out_fallback, 0);

    // Backpressure: ones on the stream must not leak into the next sample
    hold_err = 0;
    repeat (30) begin
      step(1'b1, 1'b1);
      if (out_valid !== 1'b1 || out_value !== 8'd10) hold_err++;
    end
    check("hold_stable", hold_err, 0);
    out_ready = 1'b1;
    step(1'b1, 1'b1);
    out_ready = 1'b0;
    check("handshake_valid_drop", out_valid, 0);
    check("handshake_value_kept", out_value, 10);
    feed4(4'b0010);
    step(1'b1, 1'b1);
    check("after_hold_valid", out_valid, 1);
    check("after_hold_value", out_value, 5);
    handshake();

    // bit_en gaps: enabled bits 0,1,0,1 = 5 -> 8; disabled bits are 1
    step(1'b0, 1'b1); step(1'b1, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b1); step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("gaps_cycle7_valid", out_valid, 0);
    step(1'b1, 1'b1);
    check("gaps_cycle8_valid", out_valid, 1);
    check("gaps_value", out_value, 8);
    handshake();

    // Fallback: four samples of 15, 15-10+3 = 8 at cycle 20
    repeat (19) step(1'b1, 1'b1);
    check("fallback_cycle19_valid", out_valid, 0);
    check("fallback_cycle19_rejects", reject_cnt, 3);
    step(1'b1, 1'b1);
    check("fallback_cycle20_valid", out_valid, 1);
    check("fallback_value", out_value, 8);
    check("fallback_flag", out_fallback, 1);
    check("fallback_rejects", reject_cnt, 4);
    handshake();

    // Reset after 2 of 4 bits; partial 11.. must be discarded
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    check("midreset_valid", out_valid, 0);
    check("midreset_value", out_value, 0);
    check("midreset_fallback", out_fallback, 0);
    check("midreset_rejects", reject_cnt, 0);
    feed4(4'b0011);
    step(1'b1, 1'b1);
    check("postreset_valid", out_valid, 1);
    check("postreset_value", out_value, 6);
    check("postreset_rejects", reject_cnt, 0);

    // Reset while holding a result
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    check("holdreset_valid", out_valid, 0);

    // Power-of-two range: fixed 5-cycle rhythm, value equals the 3 bits taken
    rst8 = 1'b0;
    lfsr = 16'hACE1;
    model_acc = '0;
    seen = '0;
    seq_err = 0; range_err = 0; fb_seen = 0;
    for (int c = 0; c < 5000; c++) begin
      b = lfsr[0];
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      rand_bit8 = b;
      if ((c % 5) < 3) model_acc = {model_acc[1:0], b};
      @(posedge clk);
      #1;
      if (((c + 1) % 5) == 4) begin
        if (out_valid8 !== 1'b1 || out_value8 !== {5'd0, model_acc}) seq_err++;
        if (out_value8 > 8'd7) range_err++;
        else seen[out_value8[2:0]] = 1'b1;
      end else if (out_valid8 !== 1'b0) begin
        seq_err++;
      end
      if (out_fallback8 !== 1'b0) fb_seen++;
    end
    check("pow2_sequence", seq_err, 0);
    check("pow2_range", range_err, 0);
    check("pow2_coverage", seen, 8'hFF);
    check("pow2_rejects", reject_cnt8, 0);
    check("pow2_fallback", fb_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rand_range_picker.md
# rand_range_picker

Downstream consumer of `rand_generator`'s 1-bit LFSR stream for the BuildingDrops game. It packs serial random bits into a word and maps that word uniformly onto [OFFSET, OFFSET+RANGE-1]. The mapping uses rejection sampling with a bounded-latency fallback. Results go to game logic (spawn column, block width, drop delay) over a valid/ready handshake.

## Interface
- `RANGE`, default 10: number of distinct outputs; legal range 2..32768.
- `OFFSET`, default 0: constant added to every result.
- `MAX_TRIES`, default 4: samples drawn per result before fallback; legal range 1..15.
- `OUT_W`, default 8: width of `out_value`. Elaboration error if OFFSET+RANGE-1 ≥ 2^OUT_W.
- Derived localparam `W` = clog2(RANGE): sample width. Every sample is below 2·RANGE.
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rand_bit` in 1: random bit from `rand_generator.rand`.
- `bit_en` in 1: `rand_bit` is fresh this cycle. Tie to 1 when the LFSR runs on `clk`.
- `out_ready` in 1: consumer accepts `out_value`.
- `out_valid` out 1: result available. Registered.
- `out_value` out OUT_W: result. Registered.
- `out_fallback` out 1: this result came from the fallback path. Registered.
- `reject_cnt` out 8: saturating count of rejected samples since reset. Debug only.

## Operation
- FSM states: FILL, CHECK, HOLD. Reset state is FILL.
- Reset values: `out_valid`=0, `out_value`=0, `out_fallback`=0, `reject_cnt`=0, accumulator=0, bit count=0, tries=0.
- FILL:
  - On each cycle with `bit_en`=1, `acc <= {acc[W-2:0], rand_bit}` (first bit ends up as MSB) and `bitcnt++`.
  - When the W-th bit is shifted in, `bitcnt` clears and the next state is CHECK.
  - While `bit_en`=0, acc and bitcnt hold.
- CHECK (exactly one cycle; `rand_bit` and `bit_en` ignored):
  - acc < RANGE (accept): `out_value <= acc + OFFSET`, `out_fallback <= 0`, `out_valid <= 1`, go to HOLD.
  - Otherwise (reject): `reject_cnt` increments, saturating at 255, and `tries++`.
    - If the new tries equals MAX_TRIES: `out_value <= acc - RANGE + OFFSET`, `out_fallback <= 1`, `out_valid <= 1`, go to HOLD. This subtraction is always in range because acc < 2·RANGE.
    - Else return to FILL with a fresh sample.
- HOLD:
  - `out_value`, `out_fallback` and `out_valid` stay stable. No bits are consumed.
  - On `out_valid & out_ready`: next state is FILL, tries clears, and `out_valid` drops the next cycle. `out_value` keeps its last value.
- `out_ready` is ignored when `out_valid`=0.
- RANGE a power of two: no sample is ever rejected, so `out_fallback` and `reject_cnt` stay 0.
- `rst` asserted in any state: all state returns to reset values on that edge. A partial sample or a pending result is discarded.
- Arithmetic:
  - Compare and subtract are W+1 bits unsigned.
  - The OFFSET add is OUT_W bits and never overflows, by the elaboration check.

## Timing
- Let cycle 0 be the first FILL cycle after `rst` deasserts, with `bit_en`=1 continuously.
- Bits are sampled in cycles 0..W-1. CHECK is cycle W. `out_valid`=1 from cycle W+1.
- Each rejection adds W+1 cycles.
- Worst-case latency is MAX_TRIES·(W+1) cycles from FILL entry to `out_valid`.
- Handshake at cycle t: `out_valid`=0 at t+1, and bit collection restarts at t+1.
- Best-case throughput is one result per W+2 cycles.
- No combinational path from any input to any output.

## Structure
- Package `drops_pkg` contains:
  - the `picker_state_t` enum {FILL, CHECK, HOLD};
  - a `clog2` constant function;
  - `REJECT_CNT_W` = 8.
- Sub-module `rand_bit_collector` is natural: the W-bit shift accumulator plus bit counter, with ports `bit_en`, `rand_bit`, `clear`, `word`, `word_done`.
- The FSM, accept/fallback datapath and output registers live in `rand_range_picker`.

## Test plan
- Accept path: RANGE=10, OFFSET=3, bits 0,1,1,1 → CHECK at cycle 4, `out_valid`=1 at cycle 5 with `out_value`=10 and `out_fallback`=0.
- Fallback path: RANGE=10, MAX_TRIES=4, bits 1,1,1,1 repeated → 4 rejections, `out_value`=5+OFFSET, `out_fallback`=1, `reject_cnt`=4, `out_valid`=1 at cycle 20.
- Backpressure: `out_ready`=0 for 30 cycles after `out_valid` rises → `out_value` constant and no bits consumed. Then `out_ready`=1 for 1 cycle → `out_valid`=0 next cycle, and the next sample starts from the following bits.
- `bit_en` gaps: `bit_en` toggling 1,0,1,0 with RANGE=10 → only enabled bits are shifted, and `out_valid` appears at cycle 8 (4 bits over 8 cycles), not cycle 5.
- Reset mid-op:
  - `rst` pulsed after 2 of 4 bits → all outputs 0 and the next result is built from the 4 bits after reset.
  - `rst` pulsed in HOLD → `out_valid`=0 the next cycle.
- Power-of-two with real generator: RANGE=8, `rand_generator` connected, 1000 results → all values in 0..7, `reject_cnt`=0, and every value appears at least once.
